// File: rtl/cnt_arb_pkg.sv
// Shared types for the counter command arbiter: opcodes, completion status, FSM states.
package cnt_arb_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_OVERFLOW  = 2'd1,
        ST_UNDERFLOW = 2'd2,
        ST_BAD_OP    = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // Quiet cycles the counter needs to drop back to IDLE and present its final value.
    localparam int SETTLE_CYCLES = 2;

endpackage

// File: rtl/cnt_arb_rr_pick.sv
// One-hot requester picker: cyclic search starting at ptr, or plain lowest-index
// priority when CNT_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module cnt_arb_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CNT_ARB_FIXED_PRIO_EN
            j = i;
`else
            j = (int'(ptr) + i) % NUM_REQ;
`endif
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
        any = |valid;
    end

endmodule

// File: rtl/cnt_cmd_arbiter.sv
// Schedules LOAD / UP-N / DOWN-N commands from NUM_REQ requesters onto one counter host.
// Define CNT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cnt_cmd_arbiter
    import cnt_arb_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int COUNTER_WIDTH = 16,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [2*NUM_REQ-1:0]         req_op,
    input  logic [NUM_REQ*COUNTER_WIDTH-1:0] req_arg,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         done_valid,
    output logic [IDW-1:0]               done_id,
    output logic [1:0]                   done_status,
    output logic [COUNTER_WIDTH-1:0]     done_value,
    output logic                         busy,
    output logic                         cnt_count_enable,
    output logic                         cnt_count_direction,
    output logic                         cnt_load_enable,
    output logic [COUNTER_WIDTH-1:0]     cnt_load_value,
    input  logic [COUNTER_WIDTH-1:0]     cnt_value,
    input  logic                         cnt_overflow,
    input  logic                         cnt_underflow,
    output logic [2:0]                   dbg_state
);

    // Handshake: a requester holds req_valid with op/arg stable until it sees req_ready
    // high for one cycle; the command is taken in that same cycle. Dropping valid earlier
    // simply withdraws the request.

    state_e                 state_q, state_nxt;
    status_e                status_q, status_nxt;
    logic [COUNTER_WIDTH:0] step_q, step_nxt;
    logic [1:0]             settle_q, settle_nxt;
    logic [IDW-1:0]         id_q, id_nxt;
    logic                   dir_q, dir_nxt;

    logic [NUM_REQ-1:0]       grant;
    logic [IDW-1:0]           win_idx;
    logic                     any_valid;
    logic [IDW-1:0]           pick_ptr;
    logic [1:0]               sel_op;
    logic [COUNTER_WIDTH-1:0] sel_arg;

`ifdef CNT_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDW-1:0] ptr_q;
    assign pick_ptr = ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (state_q == S_IDLE && any_valid) begin
            ptr_q <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    cnt_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (any_valid)
    );

    assign sel_op    = req_op[2*int'(win_idx) +: 2];
    assign sel_arg   = req_arg[COUNTER_WIDTH*int'(win_idx) +: COUNTER_WIDTH];
    assign req_ready = (state_q == S_IDLE) ? grant : '0;
    assign dbg_state = state_q;

    always_comb begin
        state_nxt  = state_q;
        status_nxt = status_q;
        step_nxt   = step_q;
        settle_nxt = settle_q;
        id_nxt     = id_q;
        dir_nxt    = dir_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    id_nxt     = win_idx;
                    dir_nxt    = sel_op[1];
                    status_nxt = ST_OK;
                    settle_nxt = '0;
                    step_nxt   = {1'b0, sel_arg};
                    case (sel_op)
                        OP_LOAD: state_nxt = S_LOAD;
                        OP_UP,
                        OP_DOWN: state_nxt = (sel_arg == '0) ? S_SETTLE : S_RUN;
                        default: begin
                            state_nxt  = S_DONE;
                            status_nxt = ST_BAD_OP;
                        end
                    endcase
                end
            end
            S_LOAD: state_nxt = S_SETTLE;
            S_RUN: begin
                // A wrap flag beats the step count expiring in the same cycle.
                if (cnt_overflow) begin
                    status_nxt = ST_OVERFLOW;
                    step_nxt   = '0;
                    state_nxt  = S_SETTLE;
                end else if (cnt_underflow) begin
                    status_nxt = ST_UNDERFLOW;
                    step_nxt   = '0;
                    state_nxt  = S_SETTLE;
                end else if (step_q == '0) begin
                    state_nxt = S_SETTLE;
                end else begin
                    step_nxt = step_q - 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_q == 2'(SETTLE_CYCLES - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    settle_nxt = settle_q + 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Every output below is registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= S_IDLE;
            status_q            <= ST_OK;
            step_q              <= '0;
            settle_q            <= '0;
            id_q                <= '0;
            dir_q               <= 1'b0;
            cnt_load_enable     <= 1'b0;
            cnt_load_value      <= '0;
            cnt_count_enable    <= 1'b0;
            cnt_count_direction <= 1'b0;
            done_valid          <= 1'b0;
            done_id             <= '0;
            done_status         <= '0;
            done_value          <= '0;
            busy                <= 1'b0;
        end else begin
            state_q             <= state_nxt;
            status_q            <= status_nxt;
            step_q              <= step_nxt;
            settle_q            <= settle_nxt;
            id_q                <= id_nxt;
            dir_q               <= dir_nxt;
            cnt_load_enable     <= (state_nxt == S_LOAD);
            cnt_load_value      <= (state_nxt == S_LOAD) ? sel_arg : '0;
            cnt_count_enable    <= (state_nxt == S_RUN);
            cnt_count_direction <= (state_nxt == S_RUN) && dir_nxt;
            done_valid          <= (state_nxt == S_DONE);
            done_id             <= (state_nxt == S_DONE) ? id_nxt : '0;
            done_status         <= (state_nxt == S_DONE) ? status_nxt : ST_OK;
            done_value          <= (state_nxt == S_DONE && status_nxt != ST_BAD_OP) ? cnt_value : '0;
            busy                <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_cnt_cmd_arbiter.sv
// Directed bench for cnt_cmd_arbiter driving a behavioural up/down counter host.
module tb_cnt_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [63:0] req_arg;
    logic [3:0]  req_ready;
    logic        done_valid;
    logic [1:0]  done_id;
    logic [1:0]  done_status;
    logic [15:0] done_value;
    logic        busy;
    logic        cnt_count_enable, cnt_count_direction, cnt_load_enable;
    logic [15:0] cnt_load_value;
    logic [15:0] cnt_value;
    logic        cnt_overflow, cnt_underflow;
    logic [2:0]  dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int en_cycles, dir_ones, ctrl_seen;

    always #5 clk = ~clk;

    cnt_cmd_arbiter #(.NUM_REQ(4), .COUNTER_WIDTH(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_op              (req_op),
        .req_arg             (req_arg),
        .req_ready           (req_ready),
        .done_valid          (done_valid),
        .done_id             (done_id),
        .done_status         (done_status),
        .done_value          (done_value),
        .busy                (busy),
        .cnt_count_enable    (cnt_count_enable),
        .cnt_count_direction (cnt_count_direction),
        .cnt_load_enable     (cnt_load_enable),
        .cnt_load_value      (cnt_load_value),
        .cnt_value           (cnt_value),
        .cnt_overflow        (cnt_overflow),
        .cnt_underflow       (cnt_underflow),
        .dbg_state           (dbg_state)
    );

    // Counter host: first enabled cycle arms it, later enabled cycles step; the wrap flag
    // is raised in the cycle whose step wraps.
    logic [15:0] m_value;
    logic        m_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_value <= '0;
            m_count <= 1'b0;
        end else if (cnt_load_enable) begin
            m_value <= cnt_load_value;
            m_count <= 1'b0;
        end else if (cnt_count_enable) begin
            if (!m_count) m_count <= 1'b1;
            else m_value <= cnt_count_direction ? m_value - 16'd1 : m_value + 16'd1;
        end else begin
            m_count <= 1'b0;
        end
    end

    assign cnt_value     = m_value;
    assign cnt_overflow  = cnt_count_enable && m_count && !cnt_count_direction && (m_value == 16'hFFFF);
    assign cnt_underflow = cnt_count_enable && m_count && cnt_count_direction && (m_value == 16'h0000);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_arg   = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic drive(input int id, input logic [1:0] op, input logic [15:0] arg);
        req_valid[id]         = 1'b1;
        req_op[2*id +: 2]     = op;
        req_arg[16*id +: 16]  = arg;
    endtask

    task automatic issue(input int id, input logic [1:0] op, input logic [15:0] arg,
                         output logic [3:0] rdy);
        drive(id, op, arg);
        #1;
        rdy = req_ready;
        step();
        req_valid[id] = 1'b0;
    endtask

    // Starts in the cycle after the grant; lat = cycles from req_ready to done_valid, -1 on timeout.
    task automatic wait_done(input int limit, output int lat);
        lat       = 1;
        en_cycles = 0;
        dir_ones  = 0;
        ctrl_seen = 0;
        while (done_valid !== 1'b1 && lat < limit) begin
            if (cnt_count_enable) en_cycles++;
            if (cnt_count_direction) dir_ones++;
            if (cnt_count_enable || cnt_load_enable) ctrl_seen++;
            step();
            lat++;
        end
        if (done_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({busy, done_valid, cnt_count_enable, cnt_load_enable, cnt_count_direction} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {busy, done_valid, cnt_count_enable, cnt_load_enable, cnt_count_direction});
        else pass_cnt++;
        total_cnt++;
        if ({done_id, done_status, done_value, cnt_load_value} !== 36'h0)
            $display("FAIL reset_data: got %h expected 0", {done_id, done_status, done_value, cnt_load_value});
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_load();
        logic [3:0] rdy;
        int lat;
        issue(1, 2'b00, 16'h1234, rdy);
        total_cnt++;
        if (rdy !== 4'b0010) $display("FAIL load_ready: got %b expected 0010", rdy);
        else pass_cnt++;
        total_cnt++;
        if (cnt_load_enable !== 1'b1 || cnt_load_value !== 16'h1234 || busy !== 1'b1)
            $display("FAIL load_ctrl: got en=%b val=%h busy=%b expected en=1 val=1234 busy=1",
                     cnt_load_enable, cnt_load_value, busy);
        else pass_cnt++;
        wait_done(12, lat);
        total_cnt++;
        if (lat != 4 || ctrl_seen != 1) $display("FAIL load_latency: got %0d (ctrl %0d) expected 4 (ctrl 1)", lat, ctrl_seen);
        else pass_cnt++;
        total_cnt++;
        if (done_id !== 2'd1 || done_status !== 2'd0 || done_value !== 16'h1234)
            $display("FAIL load_done: got id=%0d st=%0d val=%h expected id=1 st=0 val=1234",
                     done_id, done_status, done_value);
        else pass_cnt++;
        step();
        total_cnt++;
        if (done_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL load_done_pulse: got done=%b busy=%b expected 0 0", done_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_up();
        logic [3:0] rdy;
        int lat;
        issue(0, 2'b00, 16'h0010, rdy);
        wait_done(12, lat);
        step();
        issue(2, 2'b01, 16'd5, rdy);
        total_cnt++;
        if (rdy !== 4'b0100) $display("FAIL up_ready: got %b expected 0100", rdy);
        else pass_cnt++;
        wait_done(20, lat);
        total_cnt++;
        if (lat != 9) $display("FAIL up_latency: got %0d expected 9", lat);
        else pass_cnt++;
        total_cnt++;
        if (en_cycles != 6 || dir_ones != 0)
            $display("FAIL up_enable: got en=%0d dir=%0d expected en=6 dir=0", en_cycles, dir_ones);
        else pass_cnt++;
        total_cnt++;
        if (done_id !== 2'd2 || done_status !== 2'd0 || done_value !== 16'h0015)
            $display("FAIL up_done: got id=%0d st=%0d val=%h expected id=2 st=0 val=0015",
                     done_id, done_status, done_value);
        else pass_cnt++;
        step();
    endtask

    task automatic test_underflow();
        logic [3:0] rdy;
        int lat;
        issue(0, 2'b00, 16'h0001, rdy);
        wait_done(12, lat);
        step();
        issue(0, 2'b10, 16'd3, rdy);
        total_cnt++;
        if (rdy !== 4'b0001) $display("FAIL under_ready: got %b expected 0001", rdy);
        else pass_cnt++;
        wait_done(20, lat);
        total_cnt++;
        if (lat != 6 || en_cycles != 3 || dir_ones != 3)
            $display("FAIL under_timing: got lat=%0d en=%0d dir=%0d expected lat=6 en=3 dir=3",
                     lat, en_cycles, dir_ones);
        else pass_cnt++;
        total_cnt++;
        if (done_id !== 2'd0 || done_status !== 2'd2 || done_value !== 16'hFFFF)
            $display("FAIL under_done: got id=%0d st=%0d val=%h expected id=0 st=2 val=ffff",
                     done_id, done_status, done_value);
        else pass_cnt++;
        step();
    endtask

    task automatic test_overflow();
        logic [3:0] rdy;
        int lat;
        issue(1, 2'b00, 16'hFFFE, rdy);
        wait_done(12, lat);
        step();
        issue(1, 2'b01, 16'd3, rdy);
        wait_done(20, lat);
        total_cnt++;
        if (lat != 6 || en_cycles != 3)
            $display("FAIL over_timing: got lat=%0d en=%0d expected lat=6 en=3", lat, en_cycles);
        else pass_cnt++;
        total_cnt++;
        if (done_status !== 2'd1 || done_value !== 16'h0000)
            $display("FAIL over_done: got st=%0d val=%h expected st=1 val=0000", done_status, done_value);
        else pass_cnt++;
        step();
    endtask

    task automatic test_bad_op_back_to_back();
        logic [3:0] rdy;
        int lat;
        issue(3, 2'b11, 16'h5555, rdy);
        total_cnt++;
        if (rdy !== 4'b1000) $display("FAIL bad_ready: got %b expected 1000", rdy);
        else pass_cnt++;
        wait_done(10, lat);
        total_cnt++;
        if (lat != 1 || ctrl_seen != 0 || cnt_load_enable !== 1'b0 || cnt_count_enable !== 1'b0)
            $display("FAIL bad_timing: got lat=%0d ctrl=%0d expected lat=1 ctrl=0", lat, ctrl_seen);
        else pass_cnt++;
        total_cnt++;
        if (done_id !== 2'd3 || done_status !== 2'd3 || done_value !== 16'h0000)
            $display("FAIL bad_done: got id=%0d st=%0d val=%h expected id=3 st=3 val=0000",
                     done_id, done_status, done_value);
        else pass_cnt++;
        // A request raised during DONE waits exactly one cycle.
        drive(1, 2'b00, 16'h0042);
        #1;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL b2b_ready_in_done: got %b expected 0000", req_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL b2b_ready_next: got %b expected 0010", req_ready);
        else pass_cnt++;
        step();
        req_valid[1] = 1'b0;
        wait_done(12, lat);
        total_cnt++;
        if (lat != 4 || done_value !== 16'h0042)
            $display("FAIL b2b_done: got lat=%0d val=%h expected lat=4 val=0042", lat, done_value);
        else pass_cnt++;
        step();
    endtask

    task automatic test_round_robin();
        int waited;
        logic [3:0] exp_grant;
        apply_reset();
        for (int i = 0; i < 4; i++) drive(i, 2'b01, 16'd0);
        #1;
        for (int k = 0; k < 5; k++) begin
            waited = 0;
            while (req_ready === 4'b0000 && waited < 20) begin
                step();
                waited++;
            end
`ifdef CNT_ARB_FIXED_PRIO_EN
            exp_grant = 4'b0001;
`else
            exp_grant = 4'b0001 << (k % 4);
`endif
            total_cnt++;
            if (req_ready !== exp_grant)
                $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp_grant);
            else pass_cnt++;
            step();
        end
        req_valid = '0;
        repeat (6) step();
    endtask

    task automatic test_reset_mid();
        logic [3:0] rdy;
        int lat;
        int pulses;
        issue(2, 2'b01, 16'd100, rdy);
        repeat (40) step();
        total_cnt++;
        if (cnt_count_enable !== 1'b1 || busy !== 1'b1)
            $display("FAIL mid_running: got en=%b busy=%b expected 1 1", cnt_count_enable, busy);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done_valid, cnt_count_enable, cnt_load_enable, cnt_count_direction, req_ready,
             done_id, done_status, done_value, cnt_load_value, dbg_state} !== '0)
            $display("FAIL mid_reset_outputs: got busy=%b done=%b en=%b ld=%b state=%0d expected all 0",
                     busy, done_valid, cnt_count_enable, cnt_load_enable, dbg_state);
        else pass_cnt++;
        step();
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 120; c++) begin
            if (done_valid === 1'b1) pulses++;
            step();
        end
        total_cnt++;
        if (pulses != 0) $display("FAIL mid_no_done: got %0d pulses expected 0", pulses);
        else pass_cnt++;
        issue(1, 2'b00, 16'hBEEF, rdy);
        wait_done(12, lat);
        total_cnt++;
        if (rdy !== 4'b0010 || lat != 4 || done_status !== 2'd0 || done_value !== 16'hBEEF)
            $display("FAIL mid_recover: got rdy=%b lat=%0d st=%0d val=%h expected 0010 4 0 beef",
                     rdy, lat, done_status, done_value);
        else pass_cnt++;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_up();
        test_underflow();
        test_overflow();
        test_bad_op_back_to_back();
        test_round_robin();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cnt_cmd_arbiter.md
# cnt_cmd_arbiter

Round-robin command scheduler that shares one up/down counter host among `NUM_REQ` requesters. Each requester issues a LOAD, COUNT-UP-N or COUNT-DOWN-N command. The block sequences the counter's `count_enable`/`count_direction`/`load_enable`/`load_value` controls with the counter's fixed cycle contract, then returns the final value and overflow/underflow status to the winning requester. It sits between the requester fabric and the counter host.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `COUNTER_WIDTH`, 16, counter and argument width
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester command valid; held until `req_ready`
- `req_op`  in  2*NUM_REQ  per-requester opcode: 00 LOAD, 01 UP, 10 DOWN, 11 reserved
- `req_arg`  in  NUM_REQ*COUNTER_WIDTH  load value (LOAD) or step count N (UP/DOWN)
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse to the winner
- `done_valid`  out  1  one-cycle completion pulse
- `done_id`  out  $clog2(NUM_REQ)  requester index of the completed command
- `done_status`  out  2  0 OK, 1 OVERFLOW, 2 UNDERFLOW, 3 BAD_OP
- `done_value`  out  COUNTER_WIDTH  counter value after the command
- `busy`  out  1  high in every state except IDLE
- `cnt_count_enable`, `cnt_count_direction`, `cnt_load_enable`  out  1 each  counter controls (direction 1 = down)
- `cnt_load_value`  out  COUNTER_WIDTH  counter load data
- `cnt_value`  in  COUNTER_WIDTH  registered counter output
- `cnt_overflow`, `cnt_underflow`  in  1 each  counter wrap flags

## Operation
- FSM states: IDLE, LOAD, RUN, SETTLE, DONE. Reset state is IDLE.
- Reset: all outputs 0, round-robin pointer 0, step counter 0. Reset mid-command drops the command and emits no `done_valid`.
- IDLE, no `req_valid`:
  - Outputs stay inactive.
- IDLE, any `req_valid`:
  - The winner is the first valid index at or after the pointer, searching cyclically.
  - `req_ready[winner]` pulses in the same cycle and op/arg/id are captured.
  - The pointer moves to winner+1, mod NUM_REQ.
- Next state after a grant:
  - op 00 → LOAD.
  - op 01/10 with N≠0 → RUN.
  - op 01/10 with N=0 → SETTLE with status OK.
  - op 11 → DONE with status BAD_OP; the counter is not touched.
- LOAD: `cnt_load_enable`=1 with `cnt_load_value`=arg for exactly one cycle, then SETTLE.
- RUN:
  - `cnt_count_enable`=1 and `cnt_count_direction`=op[1], held for N+1 consecutive cycles. The first cycle moves the counter IDLE→COUNT; each later cycle is one step.
  - Then enable drops and the FSM enters SETTLE.
- RUN abort:
  - `cnt_overflow`=1 sampled during RUN → status OVERFLOW, enable low from the next cycle, SETTLE.
  - `cnt_underflow`=1 → status UNDERFLOW, same handling.
  - The flag wins over a simultaneous step-count expiry.
- SETTLE: exactly 2 cycles with all counter controls low. This lets the counter return to IDLE and `cnt_value` catch up.
- DONE: `done_valid`=1 for one cycle with `done_value`=`cnt_value`, then IDLE. For BAD_OP, `done_value` = 0.
- Step counter is COUNTER_WIDTH+1 bits, so N=2^W−1 runs without wrap.
- A requester that deasserts `req_valid` before `req_ready` is simply not granted; no error.

## Timing
- LOAD: grant cycle, then 1 + 2 + 1 cycles; `done_valid` comes 4 cycles after `req_ready`.
- UP/DOWN without abort: `done_valid` comes N+4 cycles after `req_ready`.
- BAD_OP: `done_valid` comes 1 cycle after `req_ready`.
- Back-to-back: a new grant is possible in the cycle after DONE.
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, the pointer and state.

## Configuration
- `CNT_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest valid index wins; the pointer is not implemented.
  - Undefined (default): round-robin as specified above.

## Structure
- Package `cnt_arb_pkg`:
  - opcode enum (LOAD/UP/DOWN/RSVD)
  - status enum (OK/OVERFLOW/UNDERFLOW/BAD_OP)
  - FSM state enum
  - `SETTLE_CYCLES`=2
- Sub-module `cnt_arb_rr_pick`: combinational pointer-based one-hot picker. It collapses to a priority encoder under `CNT_ARB_FIXED_PRIO_EN`.

## Test plan
All counter scenarios use the real counter host with its trojan output held at 0.

- req1 LOAD 0x1234 → `req_ready`=0010, one-cycle `cnt_load_enable` with 0x1234; 4 cycles later done id 1, status 0, value 0x1234.
- After LOAD 0x0010, req2 UP 5 → enable high for 6 cycles with direction 0; done status 0, value 0x0015, 9 cycles after ready.
- After LOAD 0x0001, req0 DOWN 3 → underflow on the 2nd step, enable drops early; done status 2, value 0xFFFF.
- All four requests held valid with op UP 0 → grants in order 0,1,2,3,0; with `CNT_ARB_FIXED_PRIO_EN`, req0 wins repeatedly.
- req3 op 11 → ready pulse, no counter control activity; done 1 cycle later with status 3, value 0.
- UP 100 in progress, `rst` pulsed at step 40 → all outputs 0 immediately, no `done_valid`; a new LOAD afterwards completes normally.
